drfm_delay_scale: RTL
=====================

Name: drfm_delay_scale

Overview:
- Sample-path stage directly downstream of the JTAG control block in the DRFM.
- Consumes the block's mode nibble, time_delay and amplitude_scale outputs, and applies them to the ADC sample stream.
- Circular-buffer delay of 0..1023 samples, then Q2.14 amplitude scaling with round and saturate.
- Feeds the Doppler/DAC stage. Doppler bits of the mode nibble are ignored here.

Parameters:
- DATA_W, 16, sample width, signed two's complement.
- ADDR_W, 10, ring-buffer address width; depth = 2^ADDR_W.
- FRAC_W, 14, fractional bits of amplitude_scale; unity gain = 2^FRAC_W.

Ports:
- Clk  in  1  sample-domain clock, same domain as the control block's Clk.
- Reset_n  in  1  asynchronous active-low reset.
- Mode  in  4  control state nibble: bit0 = delay enable, bit1 = scale enable, bit3 = Doppler (ignored); 0 = WAIT.
- Time_Delay  in  ADDR_W  requested delay in samples.
- Amplitude_Scale  in  16  unsigned Q2.14 gain.
- In_Valid  in  1  one-cycle strobe per ADC sample; no backpressure.
- In_Data  in  DATA_W  ADC sample.
- Out_Valid  out  1  one-cycle strobe per output sample.
- Out_Data  out  DATA_W  delayed, scaled sample.
- Filled  out  1  high once the buffer holds at least the active delay's worth of samples.

Behaviour:
- Reset (async assert, sync deassert internally):
  - Out_Valid=0, Out_Data=0, Filled=0.
  - Write pointer=0, fill count=0.
  - Shadow mode=0, delay=0, gain=16'h4000.
- Parameter capture:
  - Mode, Time_Delay and Amplitude_Scale are sampled into shadow registers only on cycles with In_Valid=1.
  - A new value applies from that sample onward; no mid-sample change.
- Effective values:
  - Delay D = shadow delay if mode bit0 set, else 0.
  - Gain G = shadow gain if mode bit1 set, else 16'h4000.
- Pipeline is fixed 3-cycle latency: Out_Valid is In_Valid delayed 3 cycles. Every input yields exactly one output.
  - S0 (In_Valid cycle): write In_Data at write pointer; read address = write pointer − D, mod 2^ADDR_W; write pointer increments after.
  - S1: synchronous RAM read data. If D=0, use registered In_Data (bypass) instead, because read-during-write data is undefined.
  - S2: signed product = sample × {1'b0,G}, 33-bit signed.
  - S3: add 2^(FRAC_W−1), arithmetic shift right FRAC_W, saturate to [−32768, 32767], register to Out_Data.
- Definition: Out sample n = In sample n−D, times G/16384.
- Fill count:
  - Increments per In_Valid; saturates at 2^ADDR_W−1.
  - If fill count < D at S0, the sample is flagged stale and S3 outputs 0. This applies after reset only, never after a delay change.
  - Filled = (fill count ≥ D).
- Mode=0 (WAIT): Out_Data forced 0; Out_Valid still pulses; the buffer keeps being written.
- Wrap-around: pointer arithmetic is modulo depth. D=1023 is legal; D=depth cannot be represented.
- In_Valid on consecutive cycles is supported at full rate (one sample per Clk).
- Reset mid-stream: pipeline valids are cleared and in-flight samples dropped. RAM contents are not cleared; the fill count masks them.

Decomposition:
- Shared package drfm_pkg:
  - Mode bit indices MODE_DELAY=0, MODE_SCALE=1, MODE_DOPPLER=3.
  - State codes WAIT=4'b0000, DELAY=4'b0001, SCALE=4'b0010, DOPPLER=4'b1000.
  - UNITY_GAIN=16'h4000, DATA_W, ADDR_W.
- One sub-module: drfm_ring_buffer, a simple dual-port RAM with 1 write and 1 read port, registered read address, unregistered output, inferred as block RAM.

Test Plan:
- Reset then Mode=0, continuous In_Valid, In_Data=100 → Out_Valid 3 cycles after each In_Valid, Out_Data=0.
- Mode=4'b0001, D=5, G ignored, impulse 1000 at sample 10 after 20 zeros → Out_Data=1000 exactly at output sample 15; Filled rises on sample 5.
- Mode=4'b0010, G=16'h2000, In_Data=−301 → −150 (round half up: −150.5+0.5); G=16'hFFFF, In=16'h7FFF → 16'h7FFF saturated; In=16'h8000 → 16'h8000.
- Mode=4'b0011, D=1023, G=16'h4000, ramp 0..2999 → first 1023 outputs 0, then output k = k−1023 across pointer wrap.
- D changed 5→2 mid-ramp on sample 50 → output 50 = 48, output 49 = 44; no zeros inserted.
- Reset_n pulsed low mid-stream → Out_Valid=0 and Out_Data=0 immediately; post-reset with D=3, first 3 outputs 0.

Source files
------------

// File: rtl/drfm_pkg.sv
// Shared constants for the DRFM sample path: mode nibble layout,
// control state codes and datapath widths.
package drfm_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int FRAC_W = 14;
    localparam int GAIN_W = 16;

    localparam int MODE_DELAY   = 0;
    localparam int MODE_SCALE   = 1;
    localparam int MODE_DOPPLER = 3;

    typedef enum logic [3:0] {
        WAIT    = 4'b0000,
        DELAY   = 4'b0001,
        SCALE   = 4'b0010,
        DOPPLER = 4'b1000
    } state_e;

    localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'h4000;

endpackage

// File: rtl/drfm_ring_buffer.sv
// Simple dual-port sample RAM: one write port, one read port with a
// registered address and unregistered data, so it maps onto block RAM.
module drfm_ring_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        raddr_q <= raddr;
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/drfm_delay_scale.sv
// DRFM sample path: ring-buffer delay followed by Q2.14 gain with
// round-half-up and saturation. Fixed three-cycle latency.
module drfm_delay_scale #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int FRAC_W = 14
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [3:0]        Mode,
    input  logic [ADDR_W-1:0] Time_Delay,
    input  logic [15:0]       Amplitude_Scale,
    input  logic              In_Valid,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Filled
);

    import drfm_pkg::*;

    localparam int PROD_W = 2 * DATA_W + 1;
    localparam logic signed [PROD_W-1:0] HALF =
        PROD_W'(1 << (FRAC_W - 1));
    localparam logic signed [PROD_W-1:0] MAX_S =
        PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] MIN_S =
        PROD_W'(-(1 << (DATA_W - 1)));

    logic [3:0]        mode_q, mode_n;
    logic [ADDR_W-1:0] delay_q, delay_n;
    logic [15:0]       gain_q, gain_n;
    logic [ADDR_W-1:0] d_eff;
    logic [15:0]       g_eff;
    logic [ADDR_W-1:0] wptr, fill, fill_inc;
    logic              zero_s0;

    logic              v1, z1, byp1;
    logic [DATA_W-1:0] data1;
    logic [15:0]       g1;
    logic [DATA_W-1:0] rdata;

    logic                     v2, z2;
    logic signed [PROD_W-1:0] prod2;
    logic signed [DATA_W-1:0] samp;
    logic signed [16:0]       gain_s;

    logic signed [PROD_W-1:0] sum, sh;
    logic [DATA_W-1:0]        sat_data;

    // The sample carrying new control values already uses them.
    assign mode_n  = In_Valid ? Mode : mode_q;
    assign delay_n = In_Valid ? Time_Delay : delay_q;
    assign gain_n  = In_Valid ? Amplitude_Scale : gain_q;

    always_comb begin
        d_eff    = mode_n[MODE_DELAY] ? delay_n : '0;
        g_eff    = mode_n[MODE_SCALE] ? gain_n : UNITY_GAIN;
        fill_inc = (fill == '1) ? fill : fill + 1'b1;
        zero_s0  = (fill < d_eff) || (mode_n == WAIT);
    end

    drfm_ring_buffer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ring (
        .clk  (Clk),
        .we   (In_Valid),
        .waddr(wptr),
        .wdata(In_Data),
        .raddr(wptr - d_eff),
        .rdata(rdata)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q  <= '0;
            delay_q <= '0;
            gain_q  <= UNITY_GAIN;
            wptr    <= '0;
            fill    <= '0;
            Filled  <= 1'b0;
            v1      <= 1'b0;
            z1      <= 1'b0;
            byp1    <= 1'b0;
            data1   <= '0;
            g1      <= UNITY_GAIN;
        end else begin
            v1 <= In_Valid;
            if (In_Valid) begin
                mode_q  <= Mode;
                delay_q <= Time_Delay;
                gain_q  <= Amplitude_Scale;
                wptr    <= wptr + 1'b1;
                fill    <= fill_inc;
                Filled  <= (fill_inc >= d_eff);
                z1      <= zero_s0;
                byp1    <= (d_eff == '0);
                data1   <= In_Data;
                g1      <= g_eff;
            end
        end
    end

    // Zero delay reads the slot being written; take the input directly.
    assign samp   = byp1 ? data1 : rdata;
    assign gain_s = {1'b0, g1};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v2    <= 1'b0;
            z2    <= 1'b0;
            prod2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                z2    <= z1;
                prod2 <= PROD_W'(samp) * PROD_W'(gain_s);
            end
        end
    end

    always_comb begin
        sum = prod2 + HALF;
        sh  = sum >>> FRAC_W;
        if (sh > MAX_S) begin
            sat_data = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sh < MIN_S) begin
            sat_data = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_data = sh[DATA_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
        end else begin
            Out_Valid <= v2;
            if (v2) begin
                Out_Data <= z2 ? '0 : sat_data;
            end
        end
    end

endmodule
